tdp_ram_pipe: RTL and testbench

TDP_RAM_PIPE -- requirements
Module: tdp_ram_pipe

---
 rtl/tdp_ram_pkg.sv | 18 +
 rtl/tdp_ram_read_pipe.sv | 63 ++++++
 rtl/tdp_ram_pipe.sv | 156 +++++++++++++++
 tb/tb_tdp_ram_pipe.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tdp_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tdp_ram_pkg
// Purpose : Shared defaults and the lane-count helper for the dual-port RAM.
// Revision: 1.0
// ============================================================================
package tdp_ram_pkg;

  localparam int DEFAULT_ADDR_WIDTH   = 15;
  localparam int DEFAULT_DATA_WIDTH   = 16;
  localparam int DEFAULT_READ_LATENCY = 1;

  function automatic int mask_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage : tdp_ram_pkg
`default_nettype wire

// File: rtl/tdp_ram_read_pipe.sv
`default_nettype none
// ============================================================================
// Module  : ram_read_pipe
// Purpose : Per-port valid/data delay line with a hold register on dout.
// Revision: 1.0
// ============================================================================
module ram_read_pipe
  import tdp_ram_pkg::*;
#(
  parameter int READ_LATENCY = DEFAULT_READ_LATENCY,
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  stage_valid;
  logic [DATA_WIDTH-1:0] stage_data;
  logic [DATA_WIDTH-1:0] hold_q;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("ram_read_pipe: READ_LATENCY must be 1 or 2");
  end

  if (READ_LATENCY == 2) begin : g_stage2
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_i;
        if (valid_i) data_q <= data_i;
      end
    end

    assign stage_valid = valid_q;
    assign stage_data  = data_q;
  end else begin : g_stage1
    assign stage_valid = valid_i;
    assign stage_data  = data_i;
  end

  // dout keeps the last delivered word between valid pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= '0;
    end else if (stage_valid) begin
      hold_q <= stage_data;
    end
  end

  assign valid_o = stage_valid;
  assign data_o  = stage_valid ? stage_data : hold_q;

endmodule : ram_read_pipe
`default_nettype wire

// File: rtl/tdp_ram_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tdp_ram_pipe
// Purpose : True dual-port byte-masked RAM, write-first on both ports.
// Revision: 1.0
// ============================================================================
module tdp_ram_pipe
  import tdp_ram_pkg::*;
#(
  parameter  int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter  int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter  int READ_LATENCY = DEFAULT_READ_LATENCY,
  localparam int MASK_WIDTH   = mask_width(DATA_WIDTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_portA_rd,
  input  logic                  io_portA_wr,
  input  logic [ADDR_WIDTH-1:0] io_portA_addr,
  input  logic [MASK_WIDTH-1:0] io_portA_mask,
  input  logic [DATA_WIDTH-1:0] io_portA_din,
  output logic [DATA_WIDTH-1:0] io_portA_dout,
  output logic                  io_portA_valid,
  input  logic                  io_portB_rd,
  input  logic                  io_portB_wr,
  input  logic [ADDR_WIDTH-1:0] io_portB_addr,
  input  logic [MASK_WIDTH-1:0] io_portB_mask,
  input  logic [DATA_WIDTH-1:0] io_portB_din,
  output logic [DATA_WIDTH-1:0] io_portB_dout,
  output logic                  io_portB_valid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef logic [MASK_WIDTH-1:0][7:0] word_t;

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $error("tdp_ram_pipe: DATA_WIDTH must be a positive multiple of 8");
  end

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("tdp_ram_pipe: READ_LATENCY must be 1 or 2");
  end

  logic                  port_rd    [2];
  logic                  port_wr    [2];
  logic [ADDR_WIDTH-1:0] port_addr  [2];
  logic [MASK_WIDTH-1:0] port_mask  [2];
  word_t                 port_din   [2];
  logic [DATA_WIDTH-1:0] port_dout  [2];
  logic                  port_valid [2];
  logic [MASK_WIDTH-1:0] we_mask    [2];
  logic                  same_addr;
  logic                  run;

  assign port_rd[0]   = io_portA_rd;
  assign port_wr[0]   = io_portA_wr;
  assign port_addr[0] = io_portA_addr;
  assign port_mask[0] = io_portA_mask;
  assign port_din[0]  = io_portA_din;
  assign port_rd[1]   = io_portB_rd;
  assign port_wr[1]   = io_portB_wr;
  assign port_addr[1] = io_portB_addr;
  assign port_mask[1] = io_portB_mask;
  assign port_din[1]  = io_portB_din;

  assign io_portA_dout  = port_dout[0];
  assign io_portA_valid = port_valid[0];
  assign io_portB_dout  = port_dout[1];
  assign io_portB_valid = port_valid[1];

  assign run       = reset;
  assign same_addr = (port_addr[0] == port_addr[1]);

  // Port A owns any lane both ports write at one address, so B's enable is
  // trimmed there and the array never sees two writes to the same lane.
  always_comb begin
    we_mask[0] = '0;
    we_mask[1] = '0;
    if (run && port_wr[0]) we_mask[0] = port_mask[0];
    if (run && port_wr[1]) we_mask[1] = port_mask[1] & ~(same_addr ? we_mask[0] : '0);
  end

  word_t mem_q [DEPTH];
  word_t raw_q [2];

  always_ff @(posedge clock) begin
    for (int l = 0; l < MASK_WIDTH; l++) begin
      if (we_mask[0][l]) mem_q[port_addr[0]][l] <= port_din[0][l];
      if (we_mask[1][l]) mem_q[port_addr[1]][l] <= port_din[1][l];
    end
    for (int p = 0; p < 2; p++) begin
      if (port_rd[p]) raw_q[p] <= mem_q[port_addr[p]];
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [MASK_WIDTH-1:0] fwd_sel_d;
    logic [MASK_WIDTH-1:0] fwd_sel_q;
    word_t                 fwd_data_d;
    word_t                 fwd_data_q;
    word_t                 merged;
    logic                  rd_q;

    // Lanes written this cycle at the read address bypass the array's
    // read-first output, giving write-first behaviour on and across ports.
    always_comb begin
      fwd_sel_d  = '0;
      fwd_data_d = '0;
      for (int l = 0; l < MASK_WIDTH; l++) begin
        if (we_mask[0][l] && (port_addr[0] == port_addr[p])) begin
          fwd_sel_d[l]  = 1'b1;
          fwd_data_d[l] = port_din[0][l];
        end else if (we_mask[1][l] && (port_addr[1] == port_addr[p])) begin
          fwd_sel_d[l]  = 1'b1;
          fwd_data_d[l] = port_din[1][l];
        end
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        rd_q       <= 1'b0;
        fwd_sel_q  <= '0;
        fwd_data_q <= '0;
      end else begin
        rd_q <= port_rd[p];
        if (port_rd[p]) begin
          fwd_sel_q  <= fwd_sel_d;
          fwd_data_q <= fwd_data_d;
        end
      end
    end

    always_comb begin
      merged = raw_q[p];
      for (int l = 0; l < MASK_WIDTH; l++) begin
        if (fwd_sel_q[l]) merged[l] = fwd_data_q[l];
      end
    end

    ram_read_pipe #(
      .READ_LATENCY (READ_LATENCY),
      .DATA_WIDTH   (DATA_WIDTH)
    ) u_read_pipe (
      .clk_i   (clock),
      .rst_ni  (reset),
      .valid_i (rd_q),
      .data_i  (merged),
      .valid_o (port_valid[p]),
      .data_o  (port_dout[p])
    );
  end

endmodule : tdp_ram_pipe
`default_nettype wire

// File: tb/tb_tdp_ram_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_tdp_ram_pipe
// Purpose : Scoreboard bench driving latency-1 and latency-2 RAMs in lockstep.
// Revision: 1.0
// ============================================================================
module tb_tdp_ram_pipe;

  localparam int AW = 15;
  localparam int DW = 16;
  localparam int MW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          rdA, wrA, rdB, wrB;
  logic [AW-1:0] addrA, addrB;
  logic [MW-1:0] maskA, maskB;
  logic [DW-1:0] dinA, dinB;
  logic [DW-1:0] dout  [2][2];
  logic          valid [2][2];

  tdp_ram_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) u_dut_l1 (
    .clock(clk), .reset(rst_n),
    .io_portA_rd(rdA), .io_portA_wr(wrA), .io_portA_addr(addrA), .io_portA_mask(maskA),
    .io_portA_din(dinA), .io_portA_dout(dout[0][0]), .io_portA_valid(valid[0][0]),
    .io_portB_rd(rdB), .io_portB_wr(wrB), .io_portB_addr(addrB), .io_portB_mask(maskB),
    .io_portB_din(dinB), .io_portB_dout(dout[0][1]), .io_portB_valid(valid[0][1])
  );

  tdp_ram_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2)) u_dut_l2 (
    .clock(clk), .reset(rst_n),
    .io_portA_rd(rdA), .io_portA_wr(wrA), .io_portA_addr(addrA), .io_portA_mask(maskA),
    .io_portA_din(dinA), .io_portA_dout(dout[1][0]), .io_portA_valid(valid[1][0]),
    .io_portB_rd(rdB), .io_portB_wr(wrB), .io_portB_addr(addrB), .io_portB_mask(maskB),
    .io_portB_din(dinB), .io_portB_dout(dout[1][1]), .io_portB_valid(valid[1][1])
  );

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sbq [4][$];   // index = dut*2 + port
  logic [DW-1:0] last [4];
  logic [DW-1:0] model [int];
  int            n_pass  = 0;
  int            n_fail  = 0;
  int            n_total = 0;
  int            cyc     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] post_word(
    input logic [AW-1:0] x,
    input logic wa, input logic [AW-1:0] aa, input logic [MW-1:0] ma, input logic [DW-1:0] da,
    input logic wb, input logic [AW-1:0] ab, input logic [MW-1:0] mb, input logic [DW-1:0] db);
    logic [DW-1:0] w;
    w = model.exists(int'(x)) ? model[int'(x)] : 'x;
    for (int l = 0; l < MW; l++) begin
      if (wa && aa == x && ma[l])      w[l*8 +: 8] = da[l*8 +: 8];
      else if (wb && ab == x && mb[l]) w[l*8 +: 8] = db[l*8 +: 8];
    end
    return w;
  endfunction

  task automatic push_exp(input int k, input logic [DW-1:0] d, input int due);
    exp_t e;
    e.data = d;
    e.due  = due;
    sbq[k].push_back(e);
  endtask

  // One cycle of stimulus on both ports; expectations follow write-first order.
  task automatic step(
    input logic ra, input logic wa, input logic [AW-1:0] aa, input logic [MW-1:0] ma, input logic [DW-1:0] da,
    input logic rb, input logic wb, input logic [AW-1:0] ab, input logic [MW-1:0] mb, input logic [DW-1:0] db);
    logic [DW-1:0] pa, pb;
    @(negedge clk);
    rdA = ra; wrA = wa; addrA = aa; maskA = ma; dinA = da;
    rdB = rb; wrB = wb; addrB = ab; maskB = mb; dinB = db;
    if (rst_n) begin
      pa = post_word(aa, wa, aa, ma, da, wb, ab, mb, db);
      pb = post_word(ab, wa, aa, ma, da, wb, ab, mb, db);
      if (ra) begin push_exp(0, pa, cyc + 1); push_exp(2, pa, cyc + 2); end
      if (rb) begin push_exp(1, pb, cyc + 1); push_exp(3, pb, cyc + 2); end
      if (wa && ma != 0) model[int'(aa)] = pa;
      if (wb && mb != 0) model[int'(ab)] = pb;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
  endtask

  always @(posedge clk) begin
    logic          v;
    logic [DW-1:0] d;
    string         tg;
    exp_t          e;
    cyc = cyc + 1;
    #1;
    for (int k = 0; k < 4; k++) begin
      v  = valid[k/2][k%2];
      d  = dout[k/2][k%2];
      tg = $sformatf("L%0d_port%s", k/2 + 1, (k % 2) ? "B" : "A");
      if (!rst_n) last[k] = '0;
      if (v) begin
        if (sbq[k].size() == 0) begin
          chk({tg, " unexpected_valid"}, 32'(v), 32'd0);
        end else begin
          e = sbq[k].pop_front();
          chk({tg, " dout"}, 32'(d), 32'(e.data));
          chk({tg, " latency_cycle"}, 32'(cyc), 32'(e.due));
        end
        last[k] = d;
      end else begin
        if (sbq[k].size() > 0 && sbq[k][0].due <= cyc) begin
          chk({tg, " missed_valid"}, 32'(v), 32'd1);
          void'(sbq[k].pop_front());
        end
        chk({tg, " hold"}, 32'(d), 32'(last[k]));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    rdA = 0; wrA = 0; addrA = '0; maskA = '0; dinA = '0;
    rdB = 0; wrB = 0; addrB = '0; maskB = '0; dinB = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset_valid_%0d", k), 32'(valid[k/2][k%2]), 32'd0);
      chk($sformatf("reset_dout_%0d", k),  32'(dout[k/2][k%2]),  32'd0);
    end
    @(negedge clk) rst_n = 1'b1;

    // single write then read
    step(0, 1, 15'h0010, 2'b11, 16'hBEEF, 0, 0, '0, '0, '0);
    step(1, 0, 15'h0010, 2'b00, 16'h0000, 0, 0, '0, '0, '0);
    idle(3);
    step(0, 1, 15'h0040, 2'b11, 16'h0F0F, 0, 0, '0, '0, '0);
    step(0, 1, 15'h0000, 2'b11, 16'hA0A0, 0, 1, 15'h7FFE, 2'b11, 16'h7E7E);

    // partial-mask write, read from the other port
    step(0, 0, '0, '0, '0, 0, 1, 15'h0020, 2'b11, 16'h1234);
    step(0, 1, 15'h0020, 2'b10, 16'hAB00, 0, 0, '0, '0, '0);
    step(0, 0, '0, '0, '0, 1, 0, 15'h0020, 2'b00, 16'h0000);
    idle(2);

    // simultaneous writes to the top address, lane-wise A priority
    step(0, 1, 15'h7FFF, 2'b01, 16'h1111, 0, 1, 15'h7FFF, 2'b11, 16'h2222);
    step(1, 0, 15'h7FFF, 2'b00, 16'h0000, 1, 0, 15'h7FFF, 2'b00, 16'h0000);
    idle(2);

    // cross-port write-first
    step(0, 1, 15'h0003, 2'b11, 16'h5A5A, 1, 0, 15'h0003, 2'b00, 16'h0000);
    step(1, 0, 15'h0003, 2'b00, 16'h0000, 1, 1, 15'h0003, 2'b10, 16'hC300);
    idle(2);

    // same-port read+write, then mask=0 write leaves data alone
    step(0, 1, 15'h0050, 2'b11, 16'h1122, 0, 0, '0, '0, '0);
    step(1, 1, 15'h0050, 2'b01, 16'h00FF, 0, 0, '0, '0, '0);
    step(0, 1, 15'h0010, 2'b00, 16'h0000, 0, 0, '0, '0, '0);
    step(1, 0, 15'h0010, 2'b00, 16'h0000, 1, 0, 15'h0050, 2'b00, 16'h0000);
    step(1, 0, 15'h0000, 2'b00, 16'h0000, 1, 0, 15'h7FFE, 2'b00, 16'h0000);
    idle(2);

    // an in-flight read is not disturbed by the following write
    step(0, 1, 15'h0004, 2'b11, 16'h0001, 0, 0, '0, '0, '0);
    step(1, 0, 15'h0004, 2'b00, 16'h0000, 0, 0, '0, '0, '0);
    step(0, 1, 15'h0004, 2'b11, 16'h0002, 1, 0, 15'h0004, 2'b00, 16'h0000);
    step(1, 0, 15'h0004, 2'b00, 16'h0000, 0, 0, '0, '0, '0);
    idle(3);

    // back-to-back random traffic over a small initialised window
    for (int i = 0; i < 8; i++)
      step(0, 1, 15'(15'h0100 + i), 2'b11, 16'($urandom), 0, 0, '0, '0, '0);
    for (int i = 0; i < 40; i++)
      step(1'($urandom), 1'($urandom), 15'(15'h0100 + $urandom_range(0, 7)), 2'($urandom), 16'($urandom),
           1'($urandom), 1'($urandom), 15'(15'h0100 + $urandom_range(0, 7)), 2'($urandom), 16'($urandom));
    idle(3);

    // reset one cycle after a read discards the latency-2 result
    step(1, 0, 15'h0010, 2'b00, 16'h0000, 0, 0, '0, '0, '0);
    @(negedge clk);
    rst_n = 1'b0;
    rdA = 0; wrA = 0; rdB = 0; wrB = 0;
    for (int k = 0; k < 4; k++) sbq[k].delete();
    #1;
    chk("inflight_reset_valid", 32'(valid[1][0]), 32'd0);
    chk("inflight_reset_dout",  32'(dout[1][0]),  32'd0);
    step(0, 1, 15'h0040, 2'b11, 16'hDEAD, 0, 1, 15'h0040, 2'b11, 16'hDEAD);
    idle(2);
    @(negedge clk) rst_n = 1'b1;
    idle(4);
    step(1, 0, 15'h0040, 2'b00, 16'h0000, 1, 0, 15'h7FFF, 2'b00, 16'h0000);
    idle(4);

    for (int k = 0; k < 4; k++) chk($sformatf("drain_%0d", k), 32'(sbq[k].size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_tdp_ram_pipe
`default_nettype wire
